rr_arbiter4: RTL and testbench

- Round-robin arbiter that shares one resource between four requesters.
- Its output is a one-hot grant, the same 2-to-4 encoding our decoder produces. It also outputs the 2-bit encoded grant index, so downstream muxes can select the owner.
- Sequential: the grant is held while the owner keeps requesting.
- A hold limit forces rotation when other requesters are waiting.

---
 rtl/rr_arbiter4.sv | 138 +++++++++++++
 tb/tb_rr_arbiter4.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with registered one-hot grant, encoded grant index
// and an optional hold limit that forces rotation when other requesters wait.
module rr_arbiter4 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01
    } state_t;

    localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

    state_t     state_r, state_s;
    logic [3:0] gnt_r, gnt_s;
    logic [1:0] gnt_id_r, gnt_id_s;
    logic       gnt_valid_r, gnt_valid_s;
    logic [1:0] last_r, last_s;
    logic [7:0] hold_cnt_r, hold_cnt_s;
    logic [2:0] pick_idle_s;
    logic [2:0] pick_owner_s;
    logic [3:0] others_s;

    // Circular search starting at start; returns {found, index}. Lower offsets win.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (r[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] id);
        return 4'b0001 << id;
    endfunction

    // Candidate picks for the idle and in-grant cases.
    always_comb begin
        pick_idle_s  = rr_pick(req, last_r + 2'd1);
        pick_owner_s = rr_pick(req, gnt_id_r + 2'd1);
        others_s     = req & ~onehot(gnt_id_r);
    end

    // Next-state and next-output logic; all outputs are registered below.
    always_comb begin
        state_s     = state_r;
        gnt_s       = gnt_r;
        gnt_id_s    = gnt_id_r;
        gnt_valid_s = gnt_valid_r;
        last_s      = last_r;
        hold_cnt_s  = hold_cnt_r;
        case (state_r)
            IDLE: begin
                if (pick_idle_s[2]) begin
                    gnt_s       = onehot(pick_idle_s[1:0]);
                    gnt_id_s    = pick_idle_s[1:0];
                    gnt_valid_s = 1'b1;
                    last_s      = pick_idle_s[1:0];
                    hold_cnt_s  = 8'd1;
                    state_s     = GRANT;
                end else begin
                    gnt_s       = 4'b0000;
                    gnt_valid_s = 1'b0;
                end
            end
            GRANT: begin
                if (!req[gnt_id_r] && (others_s != 4'b0000)) begin
                    gnt_s      = onehot(pick_owner_s[1:0]);
                    gnt_id_s   = pick_owner_s[1:0];
                    last_s     = pick_owner_s[1:0];
                    hold_cnt_s = 8'd1;
                end else if (!req[gnt_id_r]) begin
                    gnt_s       = 4'b0000;
                    gnt_valid_s = 1'b0;
                    hold_cnt_s  = 8'd0;
                    state_s     = IDLE;
                end else if ((MAX_HOLD_C != 8'd0) && (hold_cnt_r >= MAX_HOLD_C)
                             && (others_s != 4'b0000)) begin
                    // Owner still requesting: search from owner+1 puts it last.
                    gnt_s      = onehot(pick_owner_s[1:0]);
                    gnt_id_s   = pick_owner_s[1:0];
                    last_s     = pick_owner_s[1:0];
                    hold_cnt_s = 8'd1;
                end else if ((MAX_HOLD_C != 8'd0) && (hold_cnt_r >= MAX_HOLD_C)) begin
                    hold_cnt_s = MAX_HOLD_C;
                end else if (hold_cnt_r == 8'hFF) begin
                    hold_cnt_s = hold_cnt_r;
                end else begin
                    hold_cnt_s = hold_cnt_r + 8'd1;
                end
            end
            default: begin
                state_s     = IDLE;
                gnt_s       = 4'b0000;
                gnt_valid_s = 1'b0;
                hold_cnt_s  = 8'd0;
            end
        endcase
    end

    // State and output registers; last starts at 3 so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            gnt_r       <= 4'b0000;
            gnt_id_r    <= 2'b00;
            gnt_valid_r <= 1'b0;
            last_r      <= 2'd3;
            hold_cnt_r  <= 8'd0;
        end else begin
            state_r     <= state_s;
            gnt_r       <= gnt_s;
            gnt_id_r    <= gnt_id_s;
            gnt_valid_r <= gnt_valid_s;
            last_r      <= last_s;
            hold_cnt_r  <= hold_cnt_s;
        end
    end

    assign gnt       = gnt_r;
    assign gnt_id    = gnt_id_r;
    assign gnt_valid = gnt_valid_r;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed self-checking bench for rr_arbiter4 with MAX_HOLD = 8.
module tb_rr_arbiter4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;

    int checks = 0;
    int errors = 0;

    rr_arbiter4 #(.MAX_HOLD(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .gnt      (gnt),
        .gnt_id   (gnt_id),
        .gnt_valid(gnt_valid)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        repeat (2) @(negedge clk);
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
        checks++; if (gnt_id !== 2'b00) begin errors++; $display("FAIL reset_id: got %b expected 00", gnt_id); end
        checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", gnt_valid); end
        rst_n = 1'b1;
        req   = 4'b0001;
        #1;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL no_comb_path: got %b expected 0000", gnt); end
    endtask

    task automatic test_first_grant();
        step();
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL first_gnt: got %b expected 0001", gnt); end
        checks++; if (gnt_id !== 2'b00) begin errors++; $display("FAIL first_id: got %b expected 00", gnt_id); end
        checks++; if (gnt_valid !== 1'b1) begin errors++; $display("FAIL first_valid: got %b expected 1", gnt_valid); end
        req = 4'b0000;
        step();
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL release_gnt: got %b expected 0000", gnt); end
        checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL release_valid: got %b expected 0", gnt_valid); end
        checks++; if (gnt_id !== 2'b00) begin errors++; $display("FAIL release_id: got %b expected 00", gnt_id); end
    endtask

    task automatic test_rotation();
        logic [1:0] exp_id;
        logic [3:0] exp_gnt;
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 40; k++) begin
            step();
            exp_id  = 2'((k / 8) % 4);
            exp_gnt = 4'b0001 << exp_id;
            checks++; if (gnt !== exp_gnt) begin errors++; $display("FAIL rotation_gnt[%0d]: got %b expected %b", k, gnt, exp_gnt); end
            checks++; if (gnt_id !== exp_id) begin errors++; $display("FAIL rotation_id[%0d]: got %b expected %b", k, gnt_id, exp_id); end
            checks++; if (gnt_valid !== 1'b1) begin errors++; $display("FAIL rotation_valid[%0d]: got %b expected 1", k, gnt_valid); end
        end
    endtask

    task automatic test_handover();
        do_reset();
        req = 4'b0101;
        step();
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL handover_start: got %b expected 0001", gnt); end
        req = 4'b0100;
        step();
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL handover_gnt: got %b expected 0100", gnt); end
        checks++; if (gnt_id !== 2'b10) begin errors++; $display("FAIL handover_id: got %b expected 10", gnt_id); end
        checks++; if (gnt_valid !== 1'b1) begin errors++; $display("FAIL handover_valid: got %b expected 1", gnt_valid); end
        req = 4'b0000;
        step();
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL idle_gnt: got %b expected 0000", gnt); end
        checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b expected 0", gnt_valid); end
        checks++; if (gnt_id !== 2'b10) begin errors++; $display("FAIL idle_id_hold: got %b expected 10", gnt_id); end
    endtask

    task automatic test_idle_priority();
        req = 4'b1011;
        step();
        checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL idle_prio_gnt: got %b expected 1000", gnt); end
        checks++; if (gnt_id !== 2'b11) begin errors++; $display("FAIL idle_prio_id: got %b expected 11", gnt_id); end
        req = 4'b0011;
        step();
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL wrap_gnt: got %b expected 0001", gnt); end
        checks++; if (gnt_id !== 2'b00) begin errors++; $display("FAIL wrap_id: got %b expected 00", gnt_id); end
    endtask

    task automatic test_sole_owner();
        do_reset();
        req = 4'b0010;
        for (int k = 0; k < 20; k++) begin
            step();
            checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL sole_gnt[%0d]: got %b expected 0010", k, gnt); end
        end
        req = 4'b1010;
        step();
        checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL preempt_gnt: got %b expected 1000", gnt); end
        checks++; if (gnt_id !== 2'b11) begin errors++; $display("FAIL preempt_id: got %b expected 11", gnt_id); end
        step();
        checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL new_owner_keep: got %b expected 1000", gnt); end
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 4'b0100;
        step();
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL pre_reset_gnt: got %b expected 0100", gnt); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL async_gnt: got %b expected 0000", gnt); end
        checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL async_valid: got %b expected 0", gnt_valid); end
        checks++; if (gnt_id !== 2'b00) begin errors++; $display("FAIL async_id: got %b expected 00", gnt_id); end
        #1 rst_n = 1'b1;
        #1;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL post_release_gnt: got %b expected 0000", gnt); end
        step();
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL regrant_gnt: got %b expected 0100", gnt); end
        checks++; if (gnt_id !== 2'b10) begin errors++; $display("FAIL regrant_id: got %b expected 10", gnt_id); end
    endtask

    initial begin
        test_reset();
        test_first_grant();
        test_rotation();
        test_handover();
        test_idle_priority();
        test_sole_owner();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
